// File: rtl/dct_uart_pkg.sv
// Shared definitions for the DCT board UART paths (transmit and receive).
package dct_uart_pkg;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    // 50 MHz system clock at 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    // Line FSM encoding, kept identical on the receive side.
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/dct_uart_fifo.sv
// Synchronous first-word-fall-through FIFO shared by the UART transmit and
// receive paths. Pointers carry one extra wrap bit so full and empty are
// told apart without a separate occupancy counter.
module dct_uart_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with different wrap bits means the writer is a lap ahead.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next-pointer computation; a full FIFO refuses a push even alongside a pop.
    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no
        // path leaves a value unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the pointers alone decide which
        // entries are valid, and an unreset array maps onto plain RAM.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dct_uart_tx.sv
// DCT coefficient return path: buffers 16-bit coefficients and sends each one
// over the UART line as two 8N1 bytes, high byte first, with no idle time
// between bytes of a word or between queued words.
module dct_uart_tx
    import dct_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 16,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coef_valid,
    input  logic [DATA_W-1:0] coef_data,
    output logic              coef_ready,
    output logic              uart_tx_pin,
    output logic              tx_busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_FRAME_BITS - 3);

    uart_state_t       state_q, state_d;
    logic [15:0]       baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_sel_q, byte_sel_d;
    logic [DATA_W-1:0] shift_word_q, shift_word_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_accept;
    logic              bit_done;
    logic [7:0]        cur_byte;

    dct_uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (coef_valid),
        .push_data (coef_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign coef_ready  = !fifo_full;
    assign push_accept = coef_valid && !fifo_full;
    assign bit_done    = (baud_cnt_q == BAUD_LAST);
    assign cur_byte    = byte_sel_q ? shift_word_q[7:0] : shift_word_q[DATA_W-1 -: 8];
    assign uart_tx_pin = tx_q;
    assign tx_busy     = busy_q;

    // Line FSM: the line level for the next cycle is computed together with
    // the next state, so the pin and the state always change on the same edge.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        byte_sel_d   = byte_sel_q;
        shift_word_d = shift_word_q;
        tx_d         = tx_q;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_word_d = fifo_data;
                    byte_sel_d   = 1'b0;
                    state_d      = ST_START;
                    tx_d         = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_DATA;
                    tx_d       = cur_byte[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (!byte_sel_q) begin
                        // Low byte of the same word follows immediately.
                        byte_sel_d = 1'b1;
                        state_d    = ST_START;
                        tx_d       = 1'b0;
                    end else if (!fifo_empty) begin
                        // Next word is popped here so words stay contiguous.
                        fifo_pop     = 1'b1;
                        shift_word_d = fifo_data;
                        byte_sel_d   = 1'b0;
                        state_d      = ST_START;
                        tx_d         = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase

        // Busy reflects the state and FIFO occupancy that follow this edge.
        busy_d = (state_d != ST_IDLE) || push_accept || (!fifo_empty && !fifo_pop);
    end

    // FSM, counters, shifter and line flop; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            byte_sel_q   <= 1'b0;
            shift_word_q <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_sel_q   <= byte_sel_d;
            shift_word_q <= shift_word_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_dct_uart_tx.sv
// Self-checking bench for dct_uart_tx: a per-cycle line/busy/ready model built
// from accepted words, an independent UART receiver, and directed scenarios.
module tb_dct_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coef_valid = 1'b0;
    logic [15:0] coef_data = '0;
    logic        coef_ready;
    logic        uart_tx_pin;
    logic        tx_busy;

    always #5 clk = ~clk;

    dct_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coef_valid  (coef_valid),
        .coef_data   (coef_data),
        .coef_ready  (coef_ready),
        .uart_tx_pin (uart_tx_pin),
        .tx_busy     (tx_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        wave_q[$];     // expected line level, one entry per clock
    logic [15:0] pend_q[$];     // accepted words not yet on the line
    logic [7:0]  exp_rx[$];     // bytes the receiver must decode
    int          mdl_pos = 0;   // cycles into the word now on the line
    logic        mdl_ready = 1'b1;
    logic        s_tx, s_busy, s_ready;

    // A word is two 8N1 bytes, high byte first, each level held CPB clocks.
    task automatic load_word(input logic [15:0] w);
        logic [7:0] b;
        logic [9:0] frame;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? w[15:8] : w[7:0];
            frame = {1'b1, b, 1'b0};
            for (int i = 0; i < 10; i++)
                for (int c = 0; c < CPB; c++) wave_q.push_back(frame[i]);
        end
    endtask

    task automatic mdl_step(input logic acc, input logic [15:0] d);
        logic exp_tx, exp_busy;
        cyc++;
        if (wave_q.size() == 0 && pend_q.size() != 0) begin
            load_word(pend_q.pop_front());
            mdl_pos = 0;
        end
        if (wave_q.size() != 0) begin
            exp_tx   = wave_q.pop_front();
            exp_busy = 1'b1;
            mdl_pos++;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        if (acc) begin
            pend_q.push_back(d);
            exp_rx.push_back(d[15:8]);
            exp_rx.push_back(d[7:0]);
        end
        if (pend_q.size() != 0) exp_busy = 1'b1;
        mdl_ready = (pend_q.size() < DEPTH);
        s_tx    = uart_tx_pin;
        s_busy  = tx_busy;
        s_ready = coef_ready;
        check("line", 32'(s_tx), 32'(exp_tx));
        check("busy", 32'(s_busy), 32'(exp_busy));
        check("ready", 32'(s_ready), 32'(mdl_ready));
    endtask

    // Drive one cycle of stimulus, then check the cycle that follows the edge.
    task automatic cycle(input logic v, input logic [15:0] d, output logic acc);
        coef_valid = v;
        coef_data  = d;
        acc        = v && mdl_ready;
        @(negedge clk);
        mdl_step(acc, d);
    endtask

    task automatic idle_cycles(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, a);
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((wave_q.size() != 0 || pend_q.size() != 0) && k < max) begin
            idle_cycles(1);
            k++;
        end
        check("drain_timeout", 32'(k < max), 32'd1);
        idle_cycles(3);
    endtask

    task automatic wait_line_low(input string name, input int max);
        int k;
        k = 0;
        while (s_tx !== 1'b0 && k < max) begin
            idle_cycles(1);
            k++;
        end
        check(name, 32'(s_tx), 32'd0);
    endtask

    // ---------------- independent UART receiver ----------------
    logic [7:0] rx_q[$];
    initial begin
        logic       rx_active;
        int         rx_cnt;
        logic [9:0] rx_sh;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_sh     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (uart_tx_pin === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    rx_sh[rx_cnt / CPB] = uart_tx_pin;
                    if (rx_cnt / CPB == 9) begin
                        check("rx_framing", 32'({rx_sh[9], rx_sh[0]}), 32'b10);
                        rx_q.push_back(rx_sh[8:1]);
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scenarios ----------------
    initial begin
        logic        a, a0, a1;
        logic [0:19] a55a_line;
        logic        lvl[80];
        logic        r[8];
        logic [15:0] words[200];
        int          busy_cnt, t_fall, n_acc, sent, k;
        logic [31:0] got;

        a55a_line = 20'b01010010110010110101;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_line", 32'(uart_tx_pin), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ready", 32'(coef_ready), 32'd1);
        rst_n = 1'b1;
        idle_cycles(4);

        // Single word 0xA55A: exact line levels, 80 line cycles, busy throughout.
        rx_q.delete();
        exp_rx.delete();
        cycle(1'b1, 16'hA55A, a);
        check("a55a_accept", 32'(a), 32'd1);
        coef_valid = 1'b0;
        wait_line_low("a55a_start", 5);
        busy_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (i != 0) idle_cycles(1);
            lvl[i] = s_tx;
            if (s_busy) busy_cnt++;
        end
        for (int b = 0; b < 20; b++) begin
            got = (lvl[4*b] == lvl[4*b+1] && lvl[4*b] == lvl[4*b+2] && lvl[4*b] == lvl[4*b+3])
                  ? 32'(lvl[4*b]) : 32'h2;
            check("a55a_bit", got, 32'(a55a_line[b]));
        end
        check("a55a_busy_cycles", 32'(busy_cnt), 32'd80);
        idle_cycles(1);
        check("a55a_busy_end", 32'(s_busy), 32'd0);
        check("a55a_line_end", 32'(s_tx), 32'd1);
        idle_cycles(3);
        check("a55a_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("a55a_rx_hi", 32'(rx_q[0]), 32'hA5);
            check("a55a_rx_lo", 32'(rx_q[1]), 32'h5A);
        end

        // Back-to-back 0x0001, 0xFFFF: 160 contiguous cycles, bytes 00 01 FF FF.
        rx_q.delete();
        exp_rx.delete();
        cycle(1'b1, 16'h0001, a0);
        cycle(1'b1, 16'hFFFF, a1);
        check("b2b_accept", 32'({a0, a1}), 32'b11);
        coef_valid = 1'b0;
        wait_line_low("b2b_start", 5);
        busy_cnt = 0;
        k = 0;
        while (s_busy === 1'b1 && k < 400) begin
            busy_cnt++;
            idle_cycles(1);
            k++;
        end
        check("b2b_line_cycles", 32'(busy_cnt), 32'd160);
        idle_cycles(3);
        check("b2b_rx_count", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            check("b2b_rx0", 32'(rx_q[0]), 32'h00);
            check("b2b_rx1", 32'(rx_q[1]), 32'h01);
            check("b2b_rx2", 32'(rx_q[2]), 32'hFF);
            check("b2b_rx3", 32'(rx_q[3]), 32'hFF);
        end

        // Full FIFO: valid held 8 cycles, 5 accepts, ready back 80 cycles after first fall.
        rx_q.delete();
        exp_rx.delete();
        n_acc  = 0;
        t_fall = -1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'(16'h1100 + i), a);
            if (a) n_acc++;
            r[i] = s_ready;
            if (t_fall < 0 && s_tx === 1'b0) t_fall = cyc;
        end
        coef_valid = 1'b0;
        check("full_accepts", 32'(n_acc), 32'd5);
        for (int i = 0; i < 8; i++)
            check("full_ready_seq", 32'(r[i]), (i < 4) ? 32'd1 : 32'd0);
        check("full_fall_seen", 32'(t_fall >= 0), 32'd1);
        k = 0;
        while (s_ready !== 1'b1 && k < 200) begin
            idle_cycles(1);
            k++;
        end
        check("full_ready_return", 32'(cyc - t_fall), 32'd80);
        drain(1000);
        check("full_rx_count", 32'(rx_q.size()), 32'd10);

        // Reset during DATA bit 3 of the first byte.
        rx_q.delete();
        exp_rx.delete();
        cycle(1'b1, 16'h3C3C, a);
        coef_valid = 1'b0;
        k = 0;
        while (!(wave_q.size() != 0 && mdl_pos == 18) && k < 40) begin
            idle_cycles(1);
            k++;
        end
        check("rst_reach_bit3", 32'(mdl_pos), 32'd18);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_line", 32'(uart_tx_pin), 32'd1);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        check("rst_mid_ready", 32'(coef_ready), 32'd1);
        wave_q.delete();
        pend_q.delete();
        mdl_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(100);
        check("rst_no_rx", 32'(rx_q.size()), 32'd0);

        // Randomised traffic with random gaps.
        rx_q.delete();
        exp_rx.delete();
        for (int i = 0; i < 200; i++) words[i] = 16'($urandom());
        sent = 0;
        k    = 0;
        while (sent < 200 && k < 60000) begin
            if ($urandom_range(0, 15) == 0) idle_cycles(int'($urandom_range(1, 100)));
            cycle($urandom_range(0, 3) != 0, words[sent], a);
            if (a) sent++;
            k++;
        end
        coef_valid = 1'b0;
        check("rand_all_sent", 32'(sent), 32'd200);
        drain(2000);
        check("rand_rx_count", 32'(rx_q.size()), 32'(exp_rx.size()));
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
            check("rand_rx_byte", 32'(rx_q[i]), 32'(exp_rx[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
